// File: rtl/uart_pkg.sv
// Shared UART definitions: byte FSM states, framing sizes
// and the default bit period used by receiver and transmitter.
package uart_pkg;

  localparam int UART_DATA_BITS    = 8;
  localparam int UART_WORD_BYTES   = 4;
  localparam int UART_CLKS_PER_BIT = 434;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_WAIT_IDLE
  } rx_state_e;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: 2-FF synchroniser plus byte FSM.
// Strobes fire on the stop-bit sample cycle; the word packer registers them.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic                      Clk,
  input  logic                      rst_n,
  input  logic                      i_uart_rx,
  output logic [UART_DATA_BITS-1:0] o_byte,
  output logic                      o_byte_valid,
  output logic                      o_frame_err,
  output logic                      o_idle
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [1:0]                r_sync;
  logic                      w_rx_s;
  rx_state_e                 r_state;
  logic [CW-1:0]             r_cnt;
  logic [2:0]                r_bit;
  logic [UART_DATA_BITS-1:0] r_shift;
  logic                      w_stop_smp;

  assign w_rx_s = r_sync[1];

  // Two-flop synchroniser; idles high so reset never looks like a start bit.
  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], i_uart_rx};
    end
  end

  // Byte FSM: mid-bit sampling counted from the detected start edge.
  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (!w_rx_s) begin
            r_state <= ST_START;
            r_cnt   <= ONE;
          end
        end
        ST_START: begin
          if (r_cnt == HALF) begin
            r_cnt   <= ONE;
            r_bit   <= '0;
            r_state <= w_rx_s ? ST_IDLE : ST_DATA;
          end else begin
            r_cnt <= r_cnt + ONE;
          end
        end
        ST_DATA: begin
          if (r_cnt == FULL) begin
            r_cnt   <= ONE;
            r_shift <= {w_rx_s, r_shift[UART_DATA_BITS-1:1]};
            if (r_bit == 3'd7) begin
              r_state <= ST_STOP;
            end else begin
              r_bit <= r_bit + 3'd1;
            end
          end else begin
            r_cnt <= r_cnt + ONE;
          end
        end
        ST_STOP: begin
          if (r_cnt == FULL) begin
            r_cnt   <= ONE;
            r_state <= w_rx_s ? ST_IDLE : ST_WAIT_IDLE;
          end else begin
            r_cnt <= r_cnt + ONE;
          end
        end
        ST_WAIT_IDLE: begin
          if (w_rx_s) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign w_stop_smp   = (r_state == ST_STOP) && (r_cnt == FULL);
  assign o_byte_valid = w_stop_smp & w_rx_s;
  assign o_frame_err  = w_stop_smp & ~w_rx_s;
  assign o_byte       = r_shift;
  assign o_idle       = (r_state == ST_IDLE);

endmodule

// File: rtl/uart_rx_word.sv
// Packs four UART bytes (LSB first) into a 32-bit word with a valid strobe.
// Optional partial-word timeout: define UART_RX_TIMEOUT_EN.
module uart_rx_word
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic        Clk,
  input  logic        rst_n,
  input  logic        i_uart_rx,
  output logic [31:0] o_data,
  output logic        o_valid,
  output logic        o_frame_err
);

  logic [UART_DATA_BITS-1:0] w_byte;
  logic                      w_byte_valid;
  logic                      w_frame_err;
  logic                      w_idle;
  logic                      w_timeout;
  logic [1:0]                r_idx;
  logic [23:0]               r_word;

  uart_rx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_byte (
    .Clk          (Clk),
    .rst_n        (rst_n),
    .i_uart_rx    (i_uart_rx),
    .o_byte       (w_byte),
    .o_byte_valid (w_byte_valid),
    .o_frame_err  (w_frame_err),
    .o_idle       (w_idle)
  );

`ifdef UART_RX_TIMEOUT_EN
  localparam int TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TW       = $clog2(TO_LIMIT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TO_LIMIT - 1);

  logic [TW-1:0] r_to_cnt;

  assign w_timeout = w_idle && (r_idx != 2'd0) && (r_to_cnt == TO_LAST);

  // Idle timer for a partial word; leaving IDLE (start seen) clears it.
  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to_cnt <= '0;
    end else if (!w_idle || r_idx == 2'd0 || w_timeout) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + TW'(1);
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // Word packing; a bad stop bit drops the byte and restarts the word.
  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx       <= '0;
      r_word      <= '0;
      o_data      <= '0;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
      if (w_frame_err) begin
        o_frame_err <= 1'b1;
        r_idx       <= '0;
      end else if (w_byte_valid) begin
        r_idx <= r_idx + 2'd1;
        unique case (r_idx)
          2'd0: r_word[7:0]   <= w_byte;
          2'd1: r_word[15:8]  <= w_byte;
          2'd2: r_word[23:16] <= w_byte;
          2'd3: begin
            o_data  <= {w_byte, r_word};
            o_valid <= 1'b1;
          end
          default: r_idx <= '0;
        endcase
      end else if (w_timeout) begin
        r_idx <= '0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_word.sv
// Directed bench for uart_rx_word at 16 clocks per bit.
module tb_uart_rx_word;

  localparam int CPB = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx = 1'b1;
  logic [31:0] o_data;
  logic        o_valid;
  logic        o_frame_err;

  int n_chk = 0;
  int n_pass = 0;

  int          vcnt = 0;
  int          ecnt = 0;
  int          n_bad_chg = 0;
  int          n_wide = 0;
  logic [31:0] q_words[$];
  logic [31:0] prev_data = '0;
  logic        prev_v = 1'b0;
  logic        prev_e = 1'b0;

  uart_rx_word #(
    .CLKS_PER_BIT (CPB),
    .TIMEOUT_BITS (20)
  ) dut (
    .Clk         (clk),
    .rst_n       (rst_n),
    .i_uart_rx   (rx),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .o_frame_err (o_frame_err)
  );

  always #5 clk = ~clk;

  // Output monitor: counts strobes, records words, flags illegal changes.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_data = o_data;
      prev_v    = 1'b0;
      prev_e    = 1'b0;
    end else begin
      if (o_valid) begin
        vcnt++;
        q_words.push_back(o_data);
        if (prev_v) n_wide++;
      end
      if (o_frame_err) begin
        ecnt++;
        if (prev_e) n_wide++;
      end
      if (o_data != prev_data && !o_valid) n_bad_chg++;
      prev_data = o_data;
      prev_v    = o_valid;
      prev_e    = o_frame_err;
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic drive_bit(input logic v, input int cyc);
    rx = v;
    repeat (cyc) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive_bit(b[i], CPB);
    drive_bit(stop, CPB);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
  endtask

  int v0, e0, q0;
  logic [31:0] exp_to;

  initial begin
    #1;
    check("rst_data", o_data, 32'h0);
    check("rst_valid", {31'b0, o_valid}, 32'h0);
    check("rst_ferr", {31'b0, o_frame_err}, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // basic word
    v0 = vcnt; e0 = ecnt; q0 = q_words.size();
    send_byte(8'h78, 1'b1);
    send_byte(8'h56, 1'b1);
    send_byte(8'h34, 1'b1);
    send_byte(8'h12, 1'b1);
    drive_bit(1'b1, 2 * CPB);
    check("w1_nvalid", vcnt - v0, 1);
    check("w1_data", (q_words.size() > q0) ? q_words[q0] : 32'hx, 32'h12345678);
    check("w1_nerr", ecnt - e0, 0);

    // back-to-back words
    v0 = vcnt; q0 = q_words.size();
    send_word(32'h0000_0005);
    send_word(32'h0000_000A);
    drive_bit(1'b1, 2 * CPB);
    check("b2b_nvalid", vcnt - v0, 2);
    check("b2b_w0", (q_words.size() > q0) ? q_words[q0] : 32'hx, 32'h5);
    check("b2b_w1", (q_words.size() > q0 + 1) ? q_words[q0 + 1] : 32'hx, 32'hA);

    // short glitch in idle
    v0 = vcnt; e0 = ecnt;
    drive_bit(1'b0, 4);
    drive_bit(1'b1, 3 * CPB);
    check("glitch_nvalid", vcnt - v0, 0);
    check("glitch_nerr", ecnt - e0, 0);

    // bad stop bit on byte 2, then a clean word
    v0 = vcnt; e0 = ecnt;
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b0);
    drive_bit(1'b1, 2 * CPB);
    check("ferr_nerr", ecnt - e0, 1);
    check("ferr_nvalid", vcnt - v0, 0);
    check("ferr_data_hold", o_data, 32'hA);
    v0 = vcnt; q0 = q_words.size();
    send_word(32'hDEAD_BEEF);
    drive_bit(1'b1, 2 * CPB);
    check("ferr_next_nvalid", vcnt - v0, 1);
    check("ferr_next_data", o_data, 32'hDEAD_BEEF);

    // reset during bit 3 of byte 2
    send_byte(8'h11, 1'b1);
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 3; i++) drive_bit(1'b1, CPB);
    drive_bit(1'b0, CPB / 2);
    rst_n = 1'b0;
    #1;
    check("mid_rst_data", o_data, 32'h0);
    check("mid_rst_valid", {31'b0, o_valid}, 32'h0);
    check("mid_rst_ferr", {31'b0, o_frame_err}, 32'h0);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    v0 = vcnt;
    send_word(32'hCAFE_F00D);
    drive_bit(1'b1, 2 * CPB);
    check("post_rst_nvalid", vcnt - v0, 1);
    check("post_rst_data", o_data, 32'hCAFE_F00D);

    // partial word, long idle, then four bytes
`ifdef UART_RX_TIMEOUT_EN
    exp_to = 32'h0403_0201;
`else
    exp_to = 32'h0201_BBAA;
`endif
    v0 = vcnt;
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    drive_bit(1'b1, 25 * CPB);
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h03, 1'b1);
    send_byte(8'h04, 1'b1);
    drive_bit(1'b1, 2 * CPB);
    check("to_nvalid", vcnt - v0, 1);
    check("to_data", o_data, exp_to);

    check("data_chg_wo_valid", n_bad_chg, 0);
    check("strobe_width", n_wide, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
